// File: rtl/trace_pkg.sv
// Shared types and constants for the trace dump sequencer: FSM states,
// record section codes and header byte addressing.
package trace_pkg;

  localparam int unsigned HDR_BYTES = 16;
  localparam int unsigned HDR_IDX_W = $clog2(HDR_BYTES);
  localparam int unsigned HDR_W     = 3 * HDR_BYTES * 8;
  localparam int unsigned HDR_SEL_W = $clog2(HDR_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_FETCH,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    SEC_PT  = 2'd0,
    SEC_KEY = 2'd1,
    SEC_CT  = 2'd2,
    SEC_SEN = 2'd3
  } sec_t;

  // MSB index of byte idx of section sec inside the packed {pt, key, ct} header.
  function automatic logic [HDR_SEL_W-1:0] hdr_base(sec_t sec, logic [HDR_IDX_W-1:0] idx);
    return HDR_SEL_W'(HDR_W - 1) - HDR_SEL_W'({sec, idx, 3'b000});
  endfunction

endpackage

// File: rtl/trace_dump_sequencer_if.sv
// UART transmit handshake and sensor-memory read port used by the sequencer.
interface trace_dump_sequencer_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              tx_dv_o;
  logic [7:0]        tx_byte_o;
  logic              tx_done_i;
  logic [ADDR_W-1:0] sen_addr_o;
  logic [7:0]        sen_data_i;

  modport master (
    output tx_dv_o, tx_byte_o, sen_addr_o,
    input  tx_done_i, sen_data_i
  );

  modport slave (
    input  tx_dv_o, tx_byte_o, sen_addr_o,
    output tx_done_i, sen_data_i
  );

endinterface

// File: rtl/gap_timer.sv
// Saturating countdown that holds off done after the last transmitted byte.
module gap_timer #(
  parameter int unsigned GAP_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired_c
);

  localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(GAP_CYCLES);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Expires on the last counted cycle so the following edge can raise done.
  assign expired_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/trace_dump_sequencer.sv
// Streams one trace record (pt, key, ct, sensor samples) over uart_tx after
// each AES run, then holds a PDN-recovery gap before pulsing done.
module trace_dump_sequencer
  import trace_pkg::*;
#(
  parameter int unsigned SAMPLES    = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned GAP_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [127:0]                  pt_i,
  input  logic [127:0]                  key_i,
  input  logic [127:0]                  ct_i,
  trace_dump_sequencer_if.master        bus,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(SAMPLES - 1);
  localparam logic [HDR_IDX_W-1:0] LAST_IDX  = HDR_IDX_W'(HDR_BYTES - 1);

  state_t                state, state_n;
  sec_t                  sec, sec_n;
  logic [HDR_IDX_W-1:0]  idx, idx_n;
  logic [HDR_W-1:0]      hdr, hdr_n;
  logic                  tx_dv, tx_dv_n;
  logic [7:0]            tx_byte, tx_byte_n;
  logic [ADDR_W-1:0]     sen_addr, sen_addr_n;
  logic                  busy_n, done_n;
  logic                  gap_load, gap_count, gap_expired_c;
  logic                  hdr_last_c, ct_end_c, sen_last_c;

  assign hdr_last_c = (idx == LAST_IDX);
  assign ct_end_c   = (sec == SEC_CT) && hdr_last_c;
  assign sen_last_c = (sec == SEC_SEN) && (sen_addr == LAST_ADDR);

  gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (gap_load),
    .count     (gap_count),
    .expired_c (gap_expired_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sec      <= SEC_PT;
      idx      <= '0;
      hdr      <= '0;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
      sen_addr <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      sec      <= sec_n;
      idx      <= idx_n;
      hdr      <= hdr_n;
      tx_dv    <= tx_dv_n;
      tx_byte  <= tx_byte_n;
      sen_addr <= sen_addr_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
    end
  end

  // Next-state logic; the final tx_done goes straight to the gap so the
  // gap starts on the cycle after it.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SEND;
      ST_SEND:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done_i) begin
          if (sen_last_c) state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          else            state_n = ST_NEXT;
        end
      end
      ST_NEXT:  state_n = ((sec == SEC_SEN) || ct_end_c) ? ST_FETCH : ST_SEND;
      ST_FETCH: state_n = ST_SEND;
      ST_GAP:   if (gap_expired_c) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Output and datapath next values. The sensor address moves on the
  // tx_done edge so the RAM word is already valid during FETCH.
  always_comb begin
    sec_n      = sec;
    idx_n      = idx;
    hdr_n      = hdr;
    sen_addr_n = sen_addr;
    tx_byte_n  = tx_byte;
    tx_dv_n    = (state_n == ST_SEND);
    busy_n     = busy_o;
    done_n     = 1'b0;
    gap_load   = 1'b0;
    gap_count  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          hdr_n  = {pt_i, key_i, ct_i};
          sec_n  = SEC_PT;
          idx_n  = '0;
          busy_n = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.tx_done_i) begin
          if (ct_end_c) begin
            sen_addr_n = '0;
          end else if ((sec == SEC_SEN) && !sen_last_c) begin
            sen_addr_n = sen_addr + ADDR_W'(1);
          end
          if (sen_last_c) begin
            gap_load = 1'b1;
            if (GAP_CYCLES == 0) begin
              done_n = 1'b1;
              busy_n = 1'b0;
            end
          end
        end
      end
      ST_NEXT: begin
        if (sec != SEC_SEN) begin
          if (hdr_last_c) begin
            sec_n = sec_t'(sec + 2'd1);
            idx_n = '0;
          end else begin
            idx_n = idx + HDR_IDX_W'(1);
          end
        end
      end
      ST_FETCH: tx_byte_n = bus.sen_data_i;
      ST_GAP: begin
        gap_count = 1'b1;
        if (gap_expired_c) begin
          done_n = 1'b1;
          busy_n = 1'b0;
        end
      end
      default: ;
    endcase

    if (((state == ST_IDLE) || (state == ST_NEXT)) && (state_n == ST_SEND)) begin
      tx_byte_n = hdr_n[hdr_base(sec_n, idx_n) -: 8];
    end
  end

  assign bus.tx_dv_o    = tx_dv;
  assign bus.tx_byte_o  = tx_byte;
  assign bus.sen_addr_o = sen_addr;

endmodule
